// File: rtl/prbs_checker_if.sv
// rtl/prbs_checker_if.sv - Bit-stream and status bundle for the PRBS checker
//
// Signals:
//   en        : qualifies din on a rising clk edge
//   din       : serial PRBS bit under test
//   clr       : synchronous clear of err_count and bit_count
//   locked    : high while the checker is locked to the stream
//   err       : one-cycle pulse per mismatched bit while locked
//   err_count : saturating mismatch count (16 bits)
//   bit_count : saturating count of checked bits (32 bits)
// master drives en/din/clr; slave (the checker) drives the status outputs.

interface prbs_checker_if;
  logic        en;
  logic        din;
  logic        clr;
  logic        locked;
  logic        err;
  logic [15:0] err_count;
  logic [31:0] bit_count;

  modport master (output en, din, clr, input locked, err, err_count, bit_count);
  modport slave  (input en, din, clr, output locked, err, err_count, bit_count);
endinterface

// File: rtl/prbs_checker.sv
// rtl/prbs_checker.sv - PRBS-4 (x^4 + x^3 + 1) serial stream checker with lock/unlock
//
// Ports:
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset
//   bus : prbs_checker_if.slave (en, din, clr in; locked, err, err_count, bit_count out)
// Parameters:
//   LOCK_CNT   (1..15) consecutive matches in SEARCH needed to lock
//   UNLOCK_ERR (1..16) mismatches in one 16-bit window that drop lock
// Optional feature macro: PRBS_CHK_BITCNT_EN enables the bit_count counter;
// when undefined bit_count is tied to zero.

module prbs_checker #(
  parameter int LOCK_CNT   = 8,
  parameter int UNLOCK_ERR = 4
) (
  input  logic           clk,
  input  logic           rst,
  prbs_checker_if.slave  bus
);

  localparam logic [3:0] LOCK_CNT_W   = 4'(LOCK_CNT);
  localparam logic [4:0] UNLOCK_ERR_W = 5'(UNLOCK_ERR);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t      state_q;
  logic [3:0]  hist_q;      // [0] newest bit, [3] oldest
  logic [3:0]  lfsr_q;      // same ordering as hist_q
  logic [2:0]  fill_q;
  logic [3:0]  match_q;
  logic [3:0]  win_cnt_q;
  logic [4:0]  win_err_q;
  logic        locked_q;
  logic        err_q;
  logic [15:0] err_count_q;

  logic [3:0]  hist_d;
  logic [3:0]  lfsr_d;
  logic [3:0]  match_d;
  logic [4:0]  win_err_d;
  logic        exp_search;
  logic        exp_lock;
  logic        mis_lock;

  // b[n] = b[n-3] ^ b[n-4]; with [0] newest, b[n-3] is [2] and b[n-4] is [3].
  assign exp_search = hist_q[2] ^ hist_q[3];
  assign exp_lock   = lfsr_q[2] ^ lfsr_q[3];
  assign mis_lock   = bus.din ^ exp_lock;
  assign hist_d     = {hist_q[2:0], bus.din};
  // Locked reference free-runs on its own prediction, never on din, so one
  // corrupted input bit cannot propagate into later predictions.
  assign lfsr_d     = {lfsr_q[2:0], exp_lock};
  assign win_err_d  = win_err_q + {4'd0, mis_lock};

  always_comb begin
    match_d = 4'd0;
    if (bus.din == exp_search) begin
      // An all-zero history trivially predicts zero; refuse to count it.
      match_d = (hist_q == 4'd0) ? 4'd0 : match_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SEARCH;
      hist_q      <= '0;
      lfsr_q      <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_q <= 1'b0;
      if (bus.en) begin
        unique case (state_q)
          SEARCH: begin
            hist_q <= hist_d;
            if (fill_q != 3'd4) begin
              fill_q <= fill_q + 3'd1;
            end else begin
              match_q <= match_d;
              if (match_d == LOCK_CNT_W) begin
                state_q   <= LOCKED;
                locked_q  <= 1'b1;
                lfsr_q    <= hist_d;
                win_cnt_q <= '0;
                win_err_q <= '0;
              end
            end
          end
          LOCKED: begin
            lfsr_q    <= lfsr_d;
            win_cnt_q <= win_cnt_q + 4'd1;
            if (mis_lock) begin
              err_q <= 1'b1;
              if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
            end
            // The current bit's error is counted before the window wrap clears.
            if (win_err_d >= UNLOCK_ERR_W) begin
              state_q  <= SEARCH;
              locked_q <= 1'b0;
              hist_q   <= '0;
              fill_q   <= '0;
              match_q  <= '0;
            end else if (win_cnt_q == 4'hF) begin
              win_err_q <= '0;
            end else begin
              win_err_q <= win_err_d;
            end
          end
          default: state_q <= SEARCH;
        endcase
      end
      if (bus.clr) err_count_q <= '0;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;

`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] bit_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_count_q <= '0;
    end else if (bus.clr) begin
      bit_count_q <= '0;
    end else if (bus.en && (state_q == LOCKED) && (bit_count_q != 32'hFFFFFFFF)) begin
      bit_count_q <= bit_count_q + 32'd1;
    end
  end

  assign bus.bit_count = bit_count_q;
`else
  assign bus.bit_count = 32'h0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// tb/tb_prbs_checker.sv - Directed, table-driven testbench for prbs_checker

module tb_prbs_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prbs_checker_if bus();

  prbs_checker #(.LOCK_CNT(8), .UNLOCK_ERR(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        en;
    logic        din;
    logic        clr;
    logic        locked;
    logic        err;
    logic [15:0] ec;
    logic [31:0] bc;
  } vec_t;

  localparam int NVEC = 29;
  vec_t tbl [NVEC];

  logic seq_tab [15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                         1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  int pos    = 0;
  int total  = 0;
  int passed = 0;

  function automatic logic [31:0] bc_exp(input int n);
`ifdef PRBS_CHK_BITCNT_EN
    return 32'(n);
`else
    return 32'h0 + 32'(n * 0);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic e, input logic d, input logic c);
    bus.en  = e;
    bus.din = d;
    bus.clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, seq_tab[pos % 15], 1'b0);
      pos++;
    end
  endtask

  task automatic bad(input logic c);
    step(1'b1, ~seq_tab[pos % 15], c);
    pos++;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    pos = 0;
  endtask

  task automatic lock_fresh(input string name);
    reset_pulse();
    clean(11);
    check({name, "_prelock"}, {31'd0, bus.locked}, 32'd0);
    clean(1);
    check({name, "_lock"}, {31'd0, bus.locked}, 32'd1);
  endtask

  initial begin
    int p;
    int bc;
    bus.en  = 1'b0;
    bus.din = 1'b0;
    bus.clr = 1'b0;

    // Table: lock from seed 1000, one corrupted bit, an idle cycle, clean tail.
    p  = 0;
    bc = 0;
    for (int i = 0; i < NVEC; i++) begin
      tbl[i].en     = (i != 25);
      tbl[i].clr    = 1'b0;
      tbl[i].din    = (i == 25) ? 1'b1 : (seq_tab[p % 15] ^ (i == 20));
      if (tbl[i].en) p++;
      tbl[i].locked = (i >= 11);
      tbl[i].err    = (i == 20);
      tbl[i].ec     = (i >= 20) ? 16'd1 : 16'd0;
      if (tbl[i].en && i >= 12) bc++;
      tbl[i].bc     = bc_exp(bc);
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", {31'd0, bus.locked}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_err_count", {16'd0, bus.err_count}, 32'd0);
    check("rst_bit_count", bus.bit_count, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].en, tbl[i].din, tbl[i].clr);
      check($sformatf("vec%0d_locked", i), {31'd0, bus.locked}, {31'd0, tbl[i].locked});
      check($sformatf("vec%0d_err", i), {31'd0, bus.err}, {31'd0, tbl[i].err});
      check($sformatf("vec%0d_err_count", i), {16'd0, bus.err_count}, {16'd0, tbl[i].ec});
      check($sformatf("vec%0d_bit_count", i), bus.bit_count, tbl[i].bc);
    end

    // Four errors in one window drop lock; 12 clean bits relock.
    lock_fresh("unlock");
    for (int k = 1; k <= 4; k++) begin
      bad(1'b0);
      check($sformatf("unlock_err%0d", k), {31'd0, bus.err}, 32'd1);
      check($sformatf("unlock_ec%0d", k), {16'd0, bus.err_count}, 32'(k));
      check($sformatf("unlock_locked%0d", k), {31'd0, bus.locked}, (k == 4) ? 32'd0 : 32'd1);
    end
    clean(11);
    check("relock_pre", {31'd0, bus.locked}, 32'd0);
    check("relock_ec_hold", {16'd0, bus.err_count}, 32'd4);
    clean(1);
    check("relock", {31'd0, bus.locked}, 32'd1);

    // Three errors either side of a window wrap must not drop lock.
    lock_fresh("window");
    clean(13);
    repeat (6) bad(1'b0);
    check("window_locked", {31'd0, bus.locked}, 32'd1);
    check("window_ec", {16'd0, bus.err_count}, 32'd6);

    // clr on the same edge as an error, then async reset mid-stream.
    lock_fresh("clr");
    bad(1'b0);
    check("clr_pre_ec", {16'd0, bus.err_count}, 32'd1);
    bad(1'b1);
    check("clr_err", {31'd0, bus.err}, 32'd1);
    check("clr_ec", {16'd0, bus.err_count}, 32'd0);
    check("clr_locked", {31'd0, bus.locked}, 32'd1);
    check("clr_bit_count", bus.bit_count, 32'd0);
    bad(1'b0);
    check("post_clr_ec", {16'd0, bus.err_count}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_locked", {31'd0, bus.locked}, 32'd0);
    check("async_rst_err", {31'd0, bus.err}, 32'd0);
    check("async_rst_ec", {16'd0, bus.err_count}, 32'd0);
    check("async_rst_bc", bus.bit_count, 32'd0);
    #1;
    rst = 1'b0;

    // Stuck-at-zero input must never lock.
    reset_pulse();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check($sformatf("stuck0_locked%0d", i), {31'd0, bus.locked}, 32'd0);
    end

    // en toggling: 12th enabled bit lands on clock 23.
    reset_pulse();
    for (int c = 1; c <= 33; c++) begin
      if (c % 2 == 1) begin
        step(1'b1, seq_tab[pos % 15], 1'b0);
        pos++;
      end else begin
        step(1'b0, ~seq_tab[pos % 15], 1'b0);
      end
      if (c == 22) check("toggle_prelock", {31'd0, bus.locked}, 32'd0);
      if (c == 23) check("toggle_lock", {31'd0, bus.locked}, 32'd1);
    end
    check("toggle_bit_count", bus.bit_count, bc_exp(5));
    check("toggle_err_count", {16'd0, bus.err_count}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
